// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit,
    output logic             borrow
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {r[WIDTH-1:0], q_msb};
        // full-width compare keeps the partial remainder's top bit in the decision
        borrow  = ({r, q_msb} < {2'b00, d});
        diff    = shifted - {1'b0, d};
        r_next  = borrow ? shifted : diff;
        q_bit   = ~borrow;
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring unsigned divider, one quotient bit per clock
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   step_r;
    logic             step_qbit;
    logic             step_borrow;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q_msb  (q_q[WIDTH-1]),
        .d      (d_q),
        .r_next (step_r),
        .q_bit  (step_qbit),
        .borrow (step_borrow)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        q_d     = dividend;
                        r_d     = '0;
                        d_d     = divisor;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d = step_r;
                q_d = {q_q[WIDTH-2:0], step_qbit & ~step_borrow};
                if (cnt_q == '0) begin
                    quot_d  = q_d;
                    rem_d   = step_r[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
